// File: rtl/i2c_reg_seq.sv
// Register-access sequencer for the I2C byte-level master.
// Turns one register command (write 1 byte / read N bytes) into start, send,
// receive and datasend controls for the master, and returns read bytes and a
// completion/error status.
// Optional feature: define I2C_SEQ_REG16_EN for 16-bit register addresses.
module i2c_reg_seq #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [6:0]       cmd_dev,
  input  logic [15:0]      cmd_reg,
  input  logic [7:0]       cmd_wdata,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_last,
  output logic             done,
  output logic             err,
  input  logic             m_ready,
  input  logic             m_sended,
  input  logic             m_received,
  input  logic [7:0]       m_datareceive,
  output logic             m_start,
  output logic             m_send,
  output logic             m_receive,
  output logic [7:0]       m_datasend
);

  typedef enum logic [3:0] {
    StIdle, StLaunch, StWaitBusy, StAddrW, StRegHi, StRegLo,
    StWdata, StAddrR, StRdata, StStopWait
  } state_e;

  state_e           state_q;
  logic             rw_q;
  logic [6:0]       dev_q;
  logic [7:0]       wdata_q;
  logic [LEN_W-1:0] len_m1_q;
  logic [LEN_W-1:0] rx_idx_q;
  logic             sended_q, received_q, ready_q;

`ifdef I2C_SEQ_REG16_EN
  logic [15:0] reg_q;
`else
  logic [7:0]  reg_q;
  logic        unused_reg_hi;
  assign unused_reg_hi = ^cmd_reg[15:8];
`endif

  logic sended_rise, received_rise, received_fall, ready_rise, in_xfer, rx_last;
  assign sended_rise   = m_sended & ~sended_q;
  assign received_rise = m_received & ~received_q;
  assign received_fall = ~m_received & received_q;
  assign ready_rise    = m_ready & ~ready_q;
  assign rx_last       = (rx_idx_q == len_m1_q);
  // Master returning to ready while a byte phase is open means it gave up (NACK).
  assign in_xfer       = state_q inside {StAddrW, StRegHi, StRegLo, StWdata, StAddrR, StRdata};

  // Byte-continue controls: sampled by the master while it reports a byte boundary.
  always_comb begin
    m_send    = m_sended & ((state_q == StAddrW) | (state_q == StRegHi) |
                            ((state_q == StRegLo) & ~rw_q));
    m_receive = 1'b0;
    if (state_q == StAddrR) m_receive = m_sended;
    if (state_q == StRdata) m_receive = m_received & ~rx_last;
  end

  // Sequencer FSM with registered outputs and status edge detectors.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cmd_ready  <= 1'b0;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      m_start    <= 1'b0;
      m_datasend <= 8'h00;
      rw_q       <= 1'b0;
      dev_q      <= '0;
      reg_q      <= '0;
      wdata_q    <= '0;
      len_m1_q   <= '0;
      rx_idx_q   <= '0;
      sended_q   <= 1'b0;
      received_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      sended_q   <= m_sended;
      received_q <= m_received;
      ready_q    <= m_ready;
      m_start    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      if (in_xfer && m_ready) begin
        done    <= 1'b1;
        err     <= 1'b1;
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            cmd_ready <= m_ready;
            if (cmd_valid && cmd_ready) begin
              cmd_ready  <= 1'b0;
              rw_q       <= cmd_rw;
              dev_q      <= cmd_dev;
`ifdef I2C_SEQ_REG16_EN
              reg_q      <= cmd_reg;
`else
              reg_q      <= cmd_reg[7:0];
`endif
              wdata_q    <= cmd_wdata;
              // A length of zero reads a single byte.
              len_m1_q   <= (cmd_len == '0) ? '0 : cmd_len - {{(LEN_W-1){1'b0}}, 1'b1};
              rx_idx_q   <= '0;
              m_datasend <= {cmd_dev, 1'b0};
              m_start    <= 1'b1;
              state_q    <= StLaunch;
            end
          end
          StLaunch: state_q <= StWaitBusy;
          // Ignore m_ready until the master has actually gone busy.
          StWaitBusy: if (!m_ready) state_q <= StAddrW;
          StAddrW: if (sended_rise) begin
`ifdef I2C_SEQ_REG16_EN
            m_datasend <= reg_q[15:8];
            state_q    <= StRegHi;
`else
            m_datasend <= reg_q[7:0];
            state_q    <= StRegLo;
`endif
          end
          StRegHi: if (sended_rise) begin
            m_datasend <= reg_q[7:0];
            state_q    <= StRegLo;
          end
          StRegLo: if (sended_rise) begin
            if (rw_q) begin
              m_datasend <= {dev_q, 1'b1};
              m_start    <= 1'b1;
              state_q    <= StAddrR;
            end else begin
              m_datasend <= wdata_q;
              state_q    <= StWdata;
            end
          end
          StWdata: if (sended_rise) state_q <= StStopWait;
          StAddrR: if (sended_rise) state_q <= StRdata;
          StRdata: begin
            if (received_fall) rx_idx_q <= rx_idx_q + {{(LEN_W-1){1'b0}}, 1'b1};
            if (received_rise) begin
              rd_data  <= m_datareceive;
              rd_valid <= 1'b1;
              rd_last  <= rx_last;
              if (rx_last) state_q <= StStopWait;
            end
          end
          StStopWait: if (ready_rise) begin
            done    <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq: a scripted master drives the status lines,
// bus bytes and start pulses are logged and compared with hand-built sequences.
module tb_i2c_reg_seq;
  localparam int unsigned LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid, cmd_ready, cmd_rw;
  logic [6:0]       cmd_dev;
  logic [15:0]      cmd_reg;
  logic [7:0]       cmd_wdata;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       rd_data;
  logic             rd_valid, rd_last, done, err;
  logic             m_ready, m_sended, m_received;
  logic [7:0]       m_datareceive;
  logic             m_start, m_send, m_receive;
  logic [7:0]       m_datasend;

  int checks = 0;
  int errors = 0;

  // Bus log: 9'h100 marks a (repeated) start, otherwise the byte shifted out.
  logic [8:0] bus_log[$];
  logic       sended_prev = 1'b0;
  int         rdv_cnt = 0;

  i2c_reg_seq #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .done(done), .err(err),
    .m_ready(m_ready), .m_sended(m_sended), .m_received(m_received),
    .m_datareceive(m_datareceive), .m_start(m_start), .m_send(m_send),
    .m_receive(m_receive), .m_datasend(m_datasend)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_start) bus_log.push_back(9'h100);
    if (m_sended && !sended_prev) bus_log.push_back({1'b0, m_datasend});
    sended_prev <= m_sended;
    if (rd_valid) rdv_cnt <= rdv_cnt + 1;
  end

  function automatic bit log_match(input int base, input logic [8:0] exp[$]);
    if (bus_log.size() - base != exp.size()) return 1'b0;
    foreach (exp[i]) if (bus_log[base + i] !== exp[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string log_str(input int base);
    string s = "";
    for (int i = base; i < bus_log.size(); i++) s = {s, $sformatf(" %03h", bus_log[i])};
    return s;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a command, observe the accept cycle, then the master goes busy.
  task automatic issue(input logic rw, input logic [6:0] dev, input logic [15:0] rg,
                       input logic [7:0] wd, input logic [LEN_W-1:0] len,
                       output logic st, output logic rdy);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_len = len;
    cyc(1);
    st = m_start; rdy = cmd_ready;
    cmd_valid = 1'b0;
    cyc(2);
    m_ready = 1'b0;
  endtask

  // Master finishes shifting one byte out.
  task automatic m_byte(output logic snd, output logic rcv);
    cyc(3);
    m_sended = 1'b1;
    #1;
    snd = m_send; rcv = m_receive;
    cyc(2);
    m_sended = 1'b0;
    cyc(1);
  endtask

  task automatic addr_phase(output logic snd_a, output logic snd_r);
    logic rcv;
    m_byte(snd_a, rcv);
`ifdef I2C_SEQ_REG16_EN
    m_byte(snd_r, rcv);
`endif
    m_byte(snd_r, rcv);
  endtask

  // Master finishes receiving one byte.
  task automatic m_rbyte(input logic [7:0] d, output logic rcv, output logic rv,
                         output logic rl, output logic [7:0] rdd);
    cyc(3);
    m_datareceive = d; m_received = 1'b1;
    #1;
    rcv = m_receive;
    cyc(1);
    rv = rd_valid; rl = rd_last; rdd = rd_data;
    cyc(1);
    m_received = 1'b0;
    cyc(2);
  endtask

  task automatic m_stop(output logic dn, output logic er);
    cyc(2);
    m_ready = 1'b1;
    cyc(1);
    dn = done; er = err;
  endtask

  task automatic test_reset;
    reset = 1'b0; m_ready = 1'b1;
    cyc(3);
    checks++;
    if ({cmd_ready, rd_valid, rd_last, done, err, m_start, m_send, m_receive, rd_data,
         m_datasend} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got %b %h %h required all zero",
               {cmd_ready, rd_valid, rd_last, done, err, m_start, m_send, m_receive},
               rd_data, m_datasend);
    end
    reset = 1'b1;
    cyc(1);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write;
    logic st, rdy, sa, sr, sd, rcv, dn, er;
    logic [8:0] exp[$];
    int base = bus_log.size();
    issue(1'b0, 7'h50, 16'h0012, 8'hA5, '0, st, rdy);
    checks++;
    if ({st, rdy} !== 2'b10) begin
      errors++; $display("FAIL write_accept m_start,cmd_ready=%b required 10", {st, rdy});
    end
    addr_phase(sa, sr);
    m_byte(sd, rcv);
    checks++;
    if ({sa, sr, sd} !== 3'b110) begin
      errors++; $display("FAIL write_send m_send per byte=%b required 110", {sa, sr, sd});
    end
    m_stop(dn, er);
    checks++;
    if ({dn, er} !== 2'b10) begin
      errors++; $display("FAIL write_done done,err=%b required 10", {dn, er});
    end
    cyc(1);
    checks++;
    if ({cmd_ready, done} !== 2'b10) begin
      errors++; $display("FAIL write_ready cmd_ready,done=%b required 10", {cmd_ready, done});
    end
    exp.push_back(9'h100); exp.push_back(9'h0A0);
`ifdef I2C_SEQ_REG16_EN
    exp.push_back(9'h000);
`endif
    exp.push_back(9'h012); exp.push_back(9'h0A5);
    checks++;
    if (!log_match(base, exp)) begin
      errors++; $display("FAIL write_bus got%s", log_str(base));
    end
  endtask

  task automatic test_read;
    logic st, rdy, sa, sr, ra, rcv, rv, rl, dn, er;
    logic [7:0] rdd;
    logic [8:0] exp[$];
    int base = bus_log.size();
    int rv0 = rdv_cnt;
    issue(1'b1, 7'h50, 16'h0000, 8'h00, 4'd3, st, rdy);
    addr_phase(sa, sr);
    m_byte(sa, ra);
    checks++;
    if ({sr, ra} !== 2'b01) begin
      errors++; $display("FAIL read_ctrl regsend,addr_r_receive=%b required 01", {sr, ra});
    end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] d;
      d = 8'h11 * 8'(i + 1);
      m_rbyte(d, rcv, rv, rl, rdd);
      checks++;
      if ({rcv, rv, rl, rdd} !== {(i != 2), 1'b1, (i == 2), d}) begin
        errors++;
        $display("FAIL read_byte%0d recv,valid,last,data=%b%b%b %h required %b11%b %h",
                 i, rcv, rv, rl, rdd, (i != 2), (i == 2), d);
      end
    end
    m_stop(dn, er);
    checks++;
    if ({dn, er} !== 2'b10 || rdv_cnt - rv0 != 3) begin
      errors++;
      $display("FAIL read_done done,err=%b pulses=%0d required 10 and 3", {dn, er}, rdv_cnt - rv0);
    end
    exp.push_back(9'h100); exp.push_back(9'h0A0);
`ifdef I2C_SEQ_REG16_EN
    exp.push_back(9'h000);
`endif
    exp.push_back(9'h000); exp.push_back(9'h100); exp.push_back(9'h0A1);
    checks++;
    if (!log_match(base, exp)) begin
      errors++; $display("FAIL read_bus got%s", log_str(base));
    end
    cyc(1);
  endtask

  task automatic test_addr_nack;
    logic st, rdy, sa, rcv;
    logic [8:0] exp[$];
    int base = bus_log.size();
    int rv0 = rdv_cnt;
    issue(1'b0, 7'h3C, 16'h0001, 8'h55, '0, st, rdy);
    m_byte(sa, rcv);
    m_ready = 1'b1;
    cyc(1);
    checks++;
    if ({done, err} !== 2'b11) begin
      errors++; $display("FAIL nack_done done,err=%b required 11", {done, err});
    end
    cyc(1);
    checks++;
    if ({cmd_ready, done, err} !== 3'b100 || rdv_cnt != rv0) begin
      errors++; $display("FAIL nack_ready cmd_ready,done,err=%b required 100", {cmd_ready, done, err});
    end
    exp.push_back(9'h100); exp.push_back(9'h078);
    checks++;
    if (!log_match(base, exp)) begin
      errors++; $display("FAIL nack_bus got%s", log_str(base));
    end
  endtask

  task automatic test_read_len0;
    logic st, rdy, sa, sr, ra, rcv, rv, rl, dn, er;
    logic [7:0] rdd;
    int rv0 = rdv_cnt;
    issue(1'b1, 7'h50, 16'h0005, 8'h00, 4'd0, st, rdy);
    addr_phase(sa, sr);
    m_byte(sa, ra);
    m_rbyte(8'h5A, rcv, rv, rl, rdd);
    checks++;
    if ({rcv, rv, rl, rdd} !== {3'b011, 8'h5A}) begin
      errors++;
      $display("FAIL len0_byte recv,valid,last,data=%b%b%b %h required 011 5a", rcv, rv, rl, rdd);
    end
    m_stop(dn, er);
    checks++;
    if ({dn, er} !== 2'b10 || rdv_cnt - rv0 != 1) begin
      errors++;
      $display("FAIL len0_done done,err=%b pulses=%0d required 10 and 1", {dn, er}, rdv_cnt - rv0);
    end
    cyc(1);
  endtask

  task automatic test_reg16_write;
    logic st, rdy, sa, sr, sd, rcv, dn, er;
    logic [8:0] exp[$];
    int base = bus_log.size();
    issue(1'b0, 7'h50, 16'hBEEF, 8'h3C, '0, st, rdy);
    addr_phase(sa, sr);
    m_byte(sd, rcv);
    m_stop(dn, er);
    exp.push_back(9'h100); exp.push_back(9'h0A0);
`ifdef I2C_SEQ_REG16_EN
    exp.push_back(9'h0BE);
`endif
    exp.push_back(9'h0EF); exp.push_back(9'h03C);
    checks++;
    if (!log_match(base, exp) || {dn, er} !== 2'b10) begin
      errors++; $display("FAIL reg16_bus got%s done,err=%b", log_str(base), {dn, er});
    end
    cyc(1);
  endtask

  task automatic test_reset_mid;
    logic st, rdy, sa, sr, ra, sd, rcv, rv, rl, dn, er;
    logic [7:0] rdd;
    logic [8:0] exp[$];
    int base;
    issue(1'b1, 7'h50, 16'h0010, 8'h00, 4'd4, st, rdy);
    addr_phase(sa, sr);
    m_byte(sa, ra);
    m_rbyte(8'h77, rcv, rv, rl, rdd);
    m_rbyte(8'h88, rcv, rv, rl, rdd);
    reset = 1'b0; m_sended = 1'b1; m_received = 1'b1;
    cyc(1);
    checks++;
    if ({cmd_ready, rd_valid, rd_last, done, err, m_start, m_send, m_receive, rd_data,
         m_datasend} !== 24'h0) begin
      errors++;
      $display("FAIL midreset_outputs got %b %h %h required all zero",
               {cmd_ready, rd_valid, rd_last, done, err, m_start, m_send, m_receive},
               rd_data, m_datasend);
    end
    m_sended = 1'b0; m_received = 1'b0; m_ready = 1'b1;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_ready cmd_ready=%b required 1", cmd_ready);
    end
    base = bus_log.size();
    issue(1'b0, 7'h21, 16'h0034, 8'h56, '0, st, rdy);
    addr_phase(sa, sr);
    m_byte(sd, rcv);
    m_stop(dn, er);
    exp.push_back(9'h100); exp.push_back(9'h042);
`ifdef I2C_SEQ_REG16_EN
    exp.push_back(9'h000);
`endif
    exp.push_back(9'h034); exp.push_back(9'h056);
    checks++;
    if (!log_match(base, exp) || {dn, er} !== 2'b10) begin
      errors++; $display("FAIL midreset_next got%s done,err=%b", log_str(base), {dn, er});
    end
    cyc(1);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev = '0; cmd_reg = '0;
    cmd_wdata = '0; cmd_len = '0; m_ready = 1'b1; m_sended = 1'b0; m_received = 1'b0;
    m_datareceive = '0;
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_read_len0();
    test_reg16_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
